// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the slice-serial adder (adder_seq).
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } adder_state_e;

    function automatic int nslice(input int width, input int slice);
        return (slice > 0) ? (width / slice) : 1;
    endfunction

    // Slice index width; never narrower than one bit so NSLICE=1 still has a counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit adder with carry-out and carry into the slice MSB.
module add_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
        // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
        c_msb = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
    end

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder: one SLICE-bit slice per clock, START/DONE handshake.
// Optional macro ADDER_SUB_EN adds the SUB port (A - B - CIN as A + ~B + !CIN).
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DOUT,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO,
    output adder_state_e     DBG_STATE
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDX_W  = idx_width(NSLICE);

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_check
        $fatal(1, "adder_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    // Handshake: START is taken only when BUSY=0 (IDLE or FIN); DONE is a
    // one-cycle pulse and DOUT/COUT/OVF/ZERO are valid from DONE until the next one.

    adder_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sl_a = a_q[i*SLICE +: SLICE];
                sl_b = b_q[i*SLICE +: SLICE];
            end
        end
    end

    add_slice #(.SLICE(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (c_q),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                acc_next[i*SLICE +: SLICE] = sl_s;
            end
        end
    end

    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    a_d     = A;
`ifdef ADDER_SUB_EN
                    b_d     = SUB ? ~B : B;
                    c_d     = SUB ? ~CIN : CIN;
`else
                    b_d     = B;
                    c_d     = CIN;
`endif
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next;
                c_d   = sl_cout;
                idx_d = idx_q + IDX_W'(1);
                if (last_slice) begin
                    // The final slice is folded in via acc_next, not the stale acc_q.
                    dout_d  = acc_next;
                    cout_d  = sl_cout;
                    ovf_d   = sl_cmsb ^ sl_cout;
                    zero_d  = (acc_next == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DOUT      = dout_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;
    assign DBG_STATE = state_q;

endmodule
